// File: rtl/int_injector.sv
// int_injector: PC-triggered interrupt injector.
//
// Each channel walks a small table of trigger PCs. When the CPU's
// macroscopic PC reaches the entry under the channel pointer, the channel
// raises its irq. In level mode the irq stays high until a CPU store to
// ACK_ADDR, or until TIMEOUT cycles pass. In pulse mode it stays high for
// PULSE_LEN cycles.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : synchronous, active-low reset
//   macroscopic_pc : CPU PC (bits [1:0] ignored)
//   m_int_addr     : CPU store address (bits [1:0] ignored)
//   m_int_byteen   : CPU store byte enables (any bit set = store)
//   cfg_we         : table write strobe
//   cfg_ch/cfg_idx : target channel / table entry
//   cfg_pc         : trigger PC to store
//   cfg_valid      : entry valid bit
//   cfg_mode       : channel mode (0 = level until ack, 1 = pulse)
//   cfg_wrap       : channel pointer wrap enable
//   irq            : per-channel interrupt request (registered)
//   timeout_err    : sticky per-channel level-mode timeout flag
//   fire_count     : total fires across channels, saturating
module int_injector #(
  parameter int          N_CH      = 2,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ACK_ADDR  = 32'h0000_7f20,
  parameter int          PULSE_LEN = 1,
  parameter int          TIMEOUT   = 1024,
  localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [31:0]       cfg_pc,
  input  logic              cfg_valid,
  input  logic              cfg_mode,
  input  logic              cfg_wrap,
  output logic [N_CH-1:0]   irq,
  output logic [N_CH-1:0]   timeout_err,
  output logic [15:0]       fire_count
);

  // Pointer carries one extra bit so "walked past the last entry" is visible.
  localparam int          PTR_W       = IDX_W + 1;
  localparam int          CNT_MAX     = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
  localparam int          CNT_W       = $clog2(CNT_MAX + 1);
  localparam logic [31:0] LAST_PC_RST = 32'hffff_fffc;
  localparam logic [31:0] WORD_MASK   = ~32'h0000_0003;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_DONE   = 2'd2
  } ch_state_e;

  logic [31:0]     pc_s;
  logic            ack_s;
  logic [N_CH-1:0] fire_s;
  logic [3:0]      fire_n_s;
  logic [16:0]     fc_sum_s;
  logic [15:0]     fc_next_s;
  logic [15:0]     fire_count_r;

  assign pc_s  = macroscopic_pc & WORD_MASK;
  assign ack_s = (m_int_byteen != 4'h0) && ((m_int_addr & WORD_MASK) == ACK_ADDR);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_e        st_r, st_s;
    logic [PTR_W-1:0] ptr_r, ptr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      last_pc_r;
    logic [31:0]      tbl_pc_r [DEPTH];
    logic [DEPTH-1:0] tbl_v_r;
    logic             mode_r, wrap_r, amode_r, irq_r, tmo_r;
    logic             irq_s, fire_l_s, tmo_s, cfg_hit_s, match_s;
    logic [IDX_W-1:0] ptr_lo_s;

    assign ptr_lo_s  = ptr_r[IDX_W-1:0];
    assign cfg_hit_s = cfg_we && (cfg_ch == CH_W'(g));
    // Reads the table as registered, so a same-cycle write sees the old entry.
    assign match_s   = tbl_v_r[ptr_lo_s] && (pc_s == tbl_pc_r[ptr_lo_s]) &&
                       (pc_s != last_pc_r);

    // Channel next-state and irq logic.
    always_comb begin
      st_s     = st_r;
      ptr_s    = ptr_r;
      cnt_s    = cnt_r;
      irq_s    = 1'b0;
      fire_l_s = 1'b0;
      tmo_s    = 1'b0;
      case (st_r)
        ST_IDLE: begin
          if (ptr_r[IDX_W] || !tbl_v_r[ptr_lo_s]) begin
            st_s = ST_DONE;
          end else if (match_s) begin
            fire_l_s = 1'b1;
            irq_s    = 1'b1;
            st_s     = ST_ASSERT;
            cnt_s    = '0;
            if (wrap_r && (ptr_lo_s == IDX_W'(DEPTH - 1))) begin
              ptr_s = '0;
            end else begin
              ptr_s = ptr_r + PTR_W'(1);
            end
          end else begin
            st_s = ST_IDLE;
          end
        end
        ST_ASSERT: begin
          // Ack wins over a coincident timeout.
          if (!amode_r && ack_s) begin
            st_s = ST_IDLE;
          end else if (!amode_r && (cnt_r == CNT_W'(TIMEOUT - 1))) begin
            tmo_s = 1'b1;
            st_s  = ST_IDLE;
          end else if (amode_r && (cnt_r == CNT_W'(PULSE_LEN - 1))) begin
            st_s = ST_IDLE;
          end else begin
            irq_s = 1'b1;
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          st_s = ST_DONE;
        end
        default: begin
          st_s = ST_IDLE;
        end
      endcase
      // A config write revives a finished channel (also one finishing right now,
      // which happens while its table is still being filled after reset).
      if (cfg_hit_s && (st_s == ST_DONE)) begin
        st_s  = ST_IDLE;
        ptr_s = '0;
      end else begin
        st_s = st_s;
      end
    end

    // Channel state, stall-filter PC and sticky timeout registers.
    always_ff @(posedge clk) begin
      if (!reset) begin
        st_r      <= ST_IDLE;
        ptr_r     <= '0;
        cnt_r     <= '0;
        irq_r     <= 1'b0;
        tmo_r     <= 1'b0;
        amode_r   <= 1'b0;
        last_pc_r <= LAST_PC_RST;
      end else begin
        st_r  <= st_s;
        ptr_r <= ptr_s;
        cnt_r <= cnt_s;
        irq_r <= irq_s;
        if (tmo_s) begin
          tmo_r <= 1'b1;
        end
        // Mode is latched at fire so reconfiguration cannot alter an assertion.
        if (fire_l_s) begin
          last_pc_r <= pc_s;
          amode_r   <= mode_r;
        end else if (pc_s != last_pc_r) begin
          last_pc_r <= LAST_PC_RST;
        end
      end
    end

    // Trigger table, mode and wrap configuration.
    always_ff @(posedge clk) begin
      if (!reset) begin
        tbl_v_r <= '0;
        mode_r  <= 1'b0;
        wrap_r  <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          tbl_pc_r[i] <= 32'h0;
        end
      end else if (cfg_hit_s) begin
        tbl_pc_r[cfg_idx] <= cfg_pc & WORD_MASK;
        tbl_v_r[cfg_idx]  <= cfg_valid;
        mode_r            <= cfg_mode;
        wrap_r            <= cfg_wrap;
      end
    end

    assign fire_s[g]      = fire_l_s;
    assign irq[g]         = irq_r;
    assign timeout_err[g] = tmo_r;
  end

  // Count this cycle's fires and add them to the saturating total.
  always_comb begin
    fire_n_s = 4'd0;
    for (int i = 0; i < N_CH; i++) begin
      fire_n_s = fire_n_s + {3'b000, fire_s[i]};
    end
    fc_sum_s = {1'b0, fire_count_r} + {13'd0, fire_n_s};
    if (fc_sum_s[16]) begin
      fc_next_s = 16'hffff;
    end else begin
      fc_next_s = fc_sum_s[15:0];
    end
  end

  // Fire counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fire_count_r <= 16'h0000;
    end else begin
      fire_count_r <= fc_next_s;
    end
  end

  assign fire_count = fire_count_r;

endmodule

// File: tb/tb_int_injector.sv
// Directed bench for int_injector: a cycle table for the basic level, stall
// and pulse behaviour, then hand sequences for timeout, reset mid-assert,
// pointer wrap and the ack/fire collision.
module tb_int_injector;
  localparam int N_CH = 2, DEPTH = 2, PULSE_LEN = 3, TIMEOUT = 8;
  localparam logic [31:0] NEUT = 32'h0000_1000;
  localparam logic [31:0] ACKA = 32'h0000_7f20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] macroscopic_pc, m_int_addr, cfg_pc;
  logic [3:0]  m_int_byteen;
  logic        cfg_we, cfg_valid, cfg_mode, cfg_wrap;
  logic [0:0]  cfg_ch, cfg_idx;
  logic [1:0]  irq, timeout_err;
  logic [15:0] fire_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] fc_exp;

  always #5 clk = ~clk;

  int_injector #(.N_CH(N_CH), .DEPTH(DEPTH), .ACK_ADDR(32'h0000_7f20),
                 .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_valid(cfg_valid),
    .cfg_mode(cfg_mode), .cfg_wrap(cfg_wrap), .irq(irq),
    .timeout_err(timeout_err), .fire_count(fire_count));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        cwe;
    logic        cch;
    logic        cidx;
    logic [31:0] cpc;
    logic        cval;
    logic        cmode;
    logic        cwrap;
    logic [1:0]  eirq;
    logic [1:0]  etmo;
    logic [15:0] efc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t rv(input logic [31:0] pc, input logic [31:0] addr,
                              input logic [3:0] be, input logic [1:0] eirq,
                              input logic [1:0] etmo, input logic [15:0] efc);
    vec_t v;
    v.pc = pc; v.addr = addr; v.be = be;
    v.cwe = 1'b0; v.cch = 1'b0; v.cidx = 1'b0; v.cpc = 32'h0;
    v.cval = 1'b0; v.cmode = 1'b0; v.cwrap = 1'b0;
    v.eirq = eirq; v.etmo = etmo; v.efc = efc;
    return v;
  endfunction

  function automatic vec_t cv(input logic ch, input logic idx, input logic [31:0] cpc,
                              input logic val, input logic mode, input logic wrap,
                              input logic [1:0] eirq, input logic [1:0] etmo,
                              input logic [15:0] efc);
    vec_t v;
    v = rv(NEUT, 32'h0, 4'h0, eirq, etmo, efc);
    v.cwe = 1'b1; v.cch = ch; v.cidx = idx; v.cpc = cpc;
    v.cval = val; v.cmode = mode; v.cwrap = wrap;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    macroscopic_pc = v.pc; m_int_addr = v.addr; m_int_byteen = v.be;
    cfg_we = v.cwe; cfg_ch = v.cch; cfg_idx = v.cidx; cfg_pc = v.cpc;
    cfg_valid = v.cval; cfg_mode = v.cmode; cfg_wrap = v.cwrap;
    @(posedge clk);
    #1;
    check({tag, " irq"}, 32'(irq), 32'(v.eirq));
    check({tag, " tmo"}, 32'(timeout_err), 32'(v.etmo));
    check({tag, " fc"}, 32'(fire_count), 32'(v.efc));
  endtask

  initial begin
    reset = 1'b0;
    void'(rv(NEUT, 32'h0, 4'h0, 2'b00, 2'b00, 16'd0));
    macroscopic_pc = NEUT; m_int_addr = 32'h0; m_int_byteen = 4'h0;
    cfg_we = 1'b0; cfg_ch = 1'b0; cfg_idx = 1'b0; cfg_pc = 32'h0;
    cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_wrap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst irq", 32'(irq), 32'h0);
    check("rst tmo", 32'(timeout_err), 32'h0);
    check("rst fc", 32'(fire_count), 32'h0);
    reset = 1'b1;

    // Level fire, ack five cycles later.
    vecs.push_back(cv(1'b0, 1'b0, 32'h301c, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0));
    vecs.push_back(rv(32'h3018, 32'h0, 4'h0, 2'b00, 2'b00, 16'd0));
    vecs.push_back(rv(32'h301c, 32'h0, 4'h0, 2'b01, 2'b00, 16'd1));
    vecs.push_back(rv(32'h3020, 32'h0, 4'h0, 2'b01, 2'b00, 16'd1));
    vecs.push_back(rv(32'h3024, 32'h0, 4'h0, 2'b01, 2'b00, 16'd1));
    vecs.push_back(rv(32'h3028, 32'h0, 4'h0, 2'b01, 2'b00, 16'd1));
    vecs.push_back(rv(32'h302c, 32'h0, 4'h0, 2'b01, 2'b00, 16'd1));
    vecs.push_back(rv(32'h3030, ACKA, 4'hf, 2'b00, 2'b00, 16'd1));
    // Stalled PC with two identical entries fires once.
    vecs.push_back(cv(1'b0, 1'b0, 32'h301c, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1));
    vecs.push_back(cv(1'b0, 1'b1, 32'h301c, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1));
    vecs.push_back(rv(32'h301c, 32'h0, 4'h0, 2'b01, 2'b00, 16'd2));
    vecs.push_back(rv(32'h301c, 32'h0, 4'h0, 2'b01, 2'b00, 16'd2));
    vecs.push_back(rv(32'h301c, 32'h0, 4'h0, 2'b01, 2'b00, 16'd2));
    vecs.push_back(rv(32'h301c, 32'h7f23, 4'h1, 2'b00, 2'b00, 16'd2));
    for (int i = 0; i < 6; i++)
      vecs.push_back(rv(32'h301c, 32'h0, 4'h0, 2'b00, 2'b00, 16'd2));
    vecs.push_back(rv(32'h3020, 32'h0, 4'h0, 2'b00, 2'b00, 16'd2));
    vecs.push_back(rv(32'h301c, 32'h0, 4'h0, 2'b01, 2'b00, 16'd3));
    vecs.push_back(rv(32'h3020, 32'h7f24, 4'hf, 2'b01, 2'b00, 16'd3));
    vecs.push_back(rv(32'h3024, ACKA, 4'h0, 2'b01, 2'b00, 16'd3));
    vecs.push_back(rv(32'h3028, ACKA, 4'h8, 2'b00, 2'b00, 16'd3));
    // Pulse channel ignores acks.
    vecs.push_back(cv(1'b1, 1'b0, 32'h3040, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 16'd3));
    vecs.push_back(rv(32'h3040, 32'h0, 4'h0, 2'b10, 2'b00, 16'd4));
    vecs.push_back(rv(32'h3044, ACKA, 4'hf, 2'b10, 2'b00, 16'd4));
    vecs.push_back(rv(32'h3048, ACKA, 4'hf, 2'b10, 2'b00, 16'd4));
    vecs.push_back(rv(32'h304c, 32'h0, 4'h0, 2'b00, 2'b00, 16'd4));
    vecs.push_back(rv(32'h3040, 32'h0, 4'h0, 2'b00, 2'b00, 16'd4));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Timeout on ch0, then ack coinciding with timeout on ch1.
    fc_exp = 16'd4;
    apply(cv(1'b0, 1'b0, 32'h5000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, fc_exp), "to cfg0");
    apply(cv(1'b1, 1'b0, 32'h5100, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, fc_exp), "to cfg1");
    fc_exp++;
    apply(rv(32'h5000, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), "to fire0");
    for (int i = 0; i < 7; i++)
      apply(rv(NEUT, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), $sformatf("to hold0_%0d", i));
    apply(rv(NEUT, 32'h0, 4'h0, 2'b00, 2'b01, fc_exp), "to expire0");
    apply(rv(NEUT, ACKA, 4'hf, 2'b00, 2'b01, fc_exp), "to sticky");
    fc_exp++;
    apply(rv(32'h5100, 32'h0, 4'h0, 2'b10, 2'b01, fc_exp), "to fire1");
    for (int i = 0; i < 7; i++)
      apply(rv(NEUT, 32'h0, 4'h0, 2'b10, 2'b01, fc_exp), $sformatf("to hold1_%0d", i));
    apply(rv(NEUT, ACKA, 4'hf, 2'b00, 2'b01, fc_exp), "to ackwins");
    apply(rv(NEUT, 32'h0, 4'h0, 2'b00, 2'b01, fc_exp), "to after");

    // Reset in the middle of a level assertion.
    fc_exp++;
    apply(rv(32'h301c, 32'h0, 4'h0, 2'b01, 2'b01, fc_exp), "rst fire");
    reset = 1'b0;
    apply(rv(NEUT, 32'h0, 4'h0, 2'b00, 2'b00, 16'd0), "rst midassert");
    reset = 1'b1;
    fc_exp = 16'd0;

    // Two-entry looping code, pulse mode, with and without wrap.
    apply(cv(1'b0, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, fc_exp), "wr cfg0");
    apply(cv(1'b0, 1'b1, 32'h3004, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, fc_exp), "wr cfg1");
    for (int k = 0; k < 6; k++) begin
      fc_exp++;
      apply(rv((k % 2 == 0) ? 32'h3000 : 32'h3004, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp),
            $sformatf("wr fire%0d", k));
      apply(rv(32'h3008, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), $sformatf("wr a%0d", k));
      apply(rv(32'h300c, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), $sformatf("wr b%0d", k));
      apply(rv(32'h3010, 32'h0, 4'h0, 2'b00, 2'b00, fc_exp), $sformatf("wr c%0d", k));
    end
    apply(cv(1'b0, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, fc_exp), "nw cfg");
    for (int k = 0; k < 4; k++) begin
      if (k < 2) fc_exp++;
      apply(rv((k % 2 == 0) ? 32'h3000 : 32'h3004, 32'h0, 4'h0,
               (k < 2) ? 2'b01 : 2'b00, 2'b00, fc_exp), $sformatf("nw fire%0d", k));
      apply(rv(32'h3008, 32'h0, 4'h0, (k < 2) ? 2'b01 : 2'b00, 2'b00, fc_exp),
            $sformatf("nw a%0d", k));
      apply(rv(32'h300c, 32'h0, 4'h0, (k < 2) ? 2'b01 : 2'b00, 2'b00, fc_exp),
            $sformatf("nw b%0d", k));
      apply(rv(32'h3010, 32'h0, 4'h0, 2'b00, 2'b00, fc_exp), $sformatf("nw c%0d", k));
    end

    // Ack clears ch0 while ch1 fires; ch0 refires on the held PC next cycle.
    apply(cv(1'b0, 1'b0, 32'h7000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, fc_exp), "sim cfg0");
    apply(cv(1'b0, 1'b1, 32'h7100, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, fc_exp), "sim cfg1");
    apply(cv(1'b1, 1'b0, 32'h7100, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, fc_exp), "sim cfg2");
    fc_exp++;
    apply(rv(32'h7000, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), "sim fire0");
    apply(rv(32'h7004, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), "sim hold");
    fc_exp++;
    apply(rv(32'h7100, ACKA, 4'hf, 2'b10, 2'b00, fc_exp), "sim ackfire");
    fc_exp++;
    apply(rv(32'h7100, 32'h0, 4'h0, 2'b11, 2'b00, fc_exp), "sim refire");
    apply(rv(NEUT, 32'h0, 4'h0, 2'b11, 2'b00, fc_exp), "sim both");
    apply(rv(NEUT, 32'h0, 4'h0, 2'b01, 2'b00, fc_exp), "sim pulseend");
    apply(rv(NEUT, ACKA, 4'hf, 2'b00, 2'b00, fc_exp), "sim ack0");
    check("sim total", 32'(fire_count), 32'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
